// File: rtl/uart_rx_param.sv
// uart_rx_param - parametrised UART receiver with a one-entry holding register.
//
// Receives asynchronous serial frames (start, DATA_BITS payload LSB first,
// optional parity, STOP_BITS stop bits) using an oversample strobe from the
// baud-rate tick generator. It rejects start-bit glitches and flags parity and
// framing errors. After a framing error it waits for the line to return high
// before looking for another start bit.
//
// Optional build macro UART_RX_MAJORITY_EN: when defined, each bit is decided
// by a 2-of-3 vote over the midpoint tick and its two neighbours. The decision
// is taken one tick after the midpoint. Otherwise a single midpoint sample is
// used.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   rx         in   serial line (asynchronous, idle high)
//   sam_tick   in   one-clk oversample strobe, OVERSAMPLE per bit period
//   data_out   out  received word, meaningful while data_valid=1
//   data_valid out  holding register occupied
//   data_ready in   consumer takes the word when data_valid & data_ready
//   parity_err out  parity mismatch for the held word
//   frame_err  out  a stop bit of the held word sampled 0
//   overrun    out  held word replaced a word that was never consumed
//   busy       out  receiver FSM is not idle
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 sam_tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] S_FIRST = SW'(OVERSAMPLE / 2);
`else
  localparam logic [SW-1:0] S_FIRST = SW'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST    = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_RECOVER
  } state_t;

  state_t               state, state_n;
  logic [SW-1:0]        s_count, s_count_n;
  logic [BW-1:0]        b_count, b_count_n;
  logic                 perr, perr_n, ferr, ferr_n;
  logic                 shift_en, load;
  logic                 rx_p0, rx_s;
  logic                 bit_val;
  logic [DATA_BITS-1:0] shreg_p0;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Stage p0/p1: two-flop synchroniser, idles high so reset looks like a quiet line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Stage p2: rx_s at the two previous ticks; vote is completed with the current tick
  logic [1:0] hist_p0;
  always_ff @(posedge clk) begin
    if (sam_tick) hist_p0 <= {hist_p0[0], rx_s};
  end
  assign bit_val = majority3(hist_p0[1], hist_p0[0], rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      s_count <= '0;
      b_count <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_n;
      s_count <= s_count_n;
      b_count <= b_count_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    s_count_n = s_count;
    b_count_n = b_count;
    perr_n    = perr;
    ferr_n    = ferr;
    shift_en  = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_n   = ST_START;
          s_count_n = '0;
        end
      end
      ST_START: begin
        if (sam_tick) begin
          if (s_count == S_FIRST) begin
            s_count_n = '0;
            if (bit_val) begin
              state_n = ST_IDLE;
            end else begin
              state_n   = ST_DATA;
              b_count_n = '0;
              perr_n    = 1'b0;
              ferr_n    = 1'b0;
            end
          end else begin
            s_count_n = s_count + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (sam_tick) begin
          if (s_count == S_LAST) begin
            s_count_n = '0;
            shift_en  = 1'b1;
            if (b_count == B_LAST) begin
              b_count_n = '0;
              state_n   = (PARITY != 0) ? ST_PAR : ST_STOP;
            end else begin
              b_count_n = b_count + BW'(1);
            end
          end else begin
            s_count_n = s_count + SW'(1);
          end
        end
      end
      ST_PAR: begin
        if (sam_tick) begin
          if (s_count == S_LAST) begin
            s_count_n = '0;
            // The shift register already holds the full payload here
            perr_n    = (^{shreg_p0, bit_val}) ^ PAR_ODD;
            state_n   = ST_STOP;
          end else begin
            s_count_n = s_count + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (sam_tick) begin
          if (s_count == S_LAST) begin
            s_count_n = '0;
            if (!bit_val) ferr_n = 1'b1;
            if (b_count == STOP_LAST) begin
              // Leave at the stop midpoint so a back-to-back start edge is caught
              load      = 1'b1;
              b_count_n = '0;
              state_n   = ferr_n ? ST_RECOVER : ST_IDLE;
            end else begin
              b_count_n = b_count + BW'(1);
            end
          end else begin
            s_count_n = s_count + SW'(1);
          end
        end
      end
      ST_RECOVER: begin
        // A line held low (break) must return high before the next start bit
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (shift_en) shreg_p0 <= {bit_val, shreg_p0[DATA_BITS-1:1]};
  end

  // Holding register: a load wins over a same-cycle consume, which clears overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (load) begin
      data_out   <= shreg_p0;
      data_valid <= 1'b1;
      parity_err <= perr;
      frame_err  <= ferr_n;
      overrun    <= data_valid & ~data_ready;
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param - scoreboard bench for uart_rx_param.
// Instance u0 is 8N1, u1 is 8O1; both use OVERSAMPLE=16 and share clk/sam_tick.
// The stimulus pushes the expected word before it sends a frame. A monitor per
// instance pops and compares that word when data_valid rises, then acks it.
module tb_uart_rx_param;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sam_tick = 1'b0;
  logic       rx0, rx1;
  logic       data_ready0, data_ready1;
  logic [7:0] data_out0, data_out1;
  logic       data_valid0, data_valid1;
  logic       parity_err0, parity_err1;
  logic       frame_err0, frame_err1;
  logic       overrun0, overrun1;
  logic       busy0, busy1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  bit   ack_en0 = 1'b1;
  bit   ack_en1 = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u0 (
    .clk(clk), .reset_n(reset_n), .rx(rx0), .sam_tick(sam_tick),
    .data_out(data_out0), .data_valid(data_valid0), .data_ready(data_ready0),
    .parity_err(parity_err0), .frame_err(frame_err0), .overrun(overrun0), .busy(busy0)
  );

  uart_rx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16)) u1 (
    .clk(clk), .reset_n(reset_n), .rx(rx1), .sam_tick(sam_tick),
    .data_out(data_out1), .data_valid(data_valid1), .data_ready(data_ready1),
    .parity_err(parity_err1), .frame_err(frame_err1), .overrun(overrun1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // One-clk-wide strobe on every other clock, changed away from the rising edge
  initial forever begin
    @(negedge clk);
    sam_tick = ~sam_tick;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!sam_tick) @(posedge clk);
    end
  endtask

  task automatic set_rx(input int inst, input logic b);
    #1;
    if (inst == 0) rx0 = b;
    else rx1 = b;
  endtask

  task automatic send_bit(input int inst, input logic b);
    set_rx(inst, b);
    wait_ticks(16);
  endtask

  task automatic send_frame(input int inst, input logic [7:0] d, input bit has_par,
                            input logic pbit, input logic stopv);
    send_bit(inst, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(inst, d[i]);
    if (has_par) send_bit(inst, pbit);
    send_bit(inst, stopv);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !data_valid0 && !data_valid1) done = 1'b1;
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  // Monitor for u0
  initial begin
    data_ready0 = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en0 && data_valid0 && reset_n) begin
        if (q0.size() == 0) begin
          check("unexpected_word0", 32'(data_out0), 32'h1ff);
        end else begin
          e0 = q0.pop_front();
          check("data0", 32'(data_out0), 32'(e0.d));
          check("perr0", 32'(parity_err0), 32'(e0.pe));
          check("ferr0", 32'(frame_err0), 32'(e0.fe));
          check("ovr0", 32'(overrun0), 32'(e0.ov));
        end
        data_ready0 = 1'b1;
        @(negedge clk);
        data_ready0 = 1'b0;
        check("valid_clear0", 32'(data_valid0), 32'd0);
      end
    end
  end

  // Monitor for u1
  initial begin
    data_ready1 = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en1 && data_valid1 && reset_n) begin
        if (q1.size() == 0) begin
          check("unexpected_word1", 32'(data_out1), 32'h1ff);
        end else begin
          e1 = q1.pop_front();
          check("data1", 32'(data_out1), 32'(e1.d));
          check("perr1", 32'(parity_err1), 32'(e1.pe));
          check("ferr1", 32'(frame_err1), 32'(e1.fe));
          check("ovr1", 32'(overrun1), 32'(e1.ov));
        end
        data_ready1 = 1'b1;
        @(negedge clk);
        data_ready1 = 1'b0;
        check("valid_clear1", 32'(data_valid1), 32'd0);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    rx0 = 1'b1;
    rx1 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_valid0", 32'(data_valid0), 32'd0);
    check("rst_data0", 32'(data_out0), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_flags0", 32'({parity_err0, frame_err0, overrun0}), 32'd0);
    check("rst_valid1", 32'(data_valid1), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(8);

    // 8N1 0xA5, then odd parity: good parity bit, then bad parity bit
    q0.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    send_bit(0, 1'b1);
    drain();
    q1.push_back('{8'h3C, 1'b0, 1'b0, 1'b0});
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
    send_bit(1, 1'b1);
    q1.push_back('{8'h3C, 1'b1, 1'b0, 1'b0});
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1);
    send_bit(1, 1'b1);
    drain();

    // Start glitch of 4 ticks is rejected
    set_rx(0, 1'b0);
    wait_ticks(2);
    check("glitch_busy", 32'(busy0), 32'd1);
    wait_ticks(2);
    set_rx(0, 1'b1);
    wait_ticks(40);
    check("glitch_idle", 32'(busy0), 32'd0);
    check("glitch_novalid", 32'(data_valid0), 32'd0);
    q0.push_back('{8'h55, 1'b0, 1'b0, 1'b0});
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    send_bit(0, 1'b1);
    drain();

    // Back-to-back frames with no consumer: second overwrites first
    ack_en0 = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    @(negedge clk);
    check("ovr_valid", 32'(data_valid0), 32'd1);
    check("ovr_data", 32'(data_out0), 32'h22);
    check("ovr_flag", 32'(overrun0), 32'd1);
    q0.push_back('{8'h22, 1'b0, 1'b0, 1'b1});
    ack_en0 = 1'b1;
    drain();
    check("ovr_cleared", 32'(overrun0), 32'd0);
    check("data_hold", 32'(data_out0), 32'h22);

    // Stop bit 0 followed by a 40-bit break: one word, then recovery
    q0.push_back('{8'h00, 1'b0, 1'b1, 1'b0});
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_ticks(40 * 16);
    check("break_busy", 32'(busy0), 32'd1);
    check("break_q_empty", 32'(q0.size()), 32'd0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    check("break_idle", 32'(busy0), 32'd0);
    q0.push_back('{8'h7E, 1'b0, 1'b0, 1'b0});
    send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1);
    send_bit(0, 1'b1);
    drain();

    // Reset in the middle of data bit 4 discards the frame
    send_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, (i % 2) == 1);
    set_rx(0, 1'b1);
    wait_ticks(8);
    check("pre_reset_busy", 32'(busy0), 32'd1);
    #2;
    reset_n = 1'b0;
    #2;
    check("mid_rst_busy", 32'(busy0), 32'd0);
    check("mid_rst_data", 32'(data_out0), 32'd0);
    check("mid_rst_valid", 32'(data_valid0), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(32);
    q0.push_back('{8'h81, 1'b0, 1'b0, 1'b0});
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    send_bit(0, 1'b1);
    drain();
    check("final_q0", 32'(q0.size()), 32'd0);
    check("final_q1", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 9-bit receiver FSM. Configurable data width, parity mode, stop-bit count and oversampling ratio. Adds start-bit glitch rejection, parity/framing error detection, a break-recovery state, and a one-entry output holding register with valid/ready handshake and overrun flag. Sits between the baud-rate tick generator (sam_tick) and the consuming logic (FIFO or CPU register block).

Parameters:
DATA_BITS, 8, payload bits per frame, legal 5..9, LSB received first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked, legal 1 or 2
OVERSAMPLE, 16, sam_tick pulses per bit period, power of 2, >= 8

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
rx  input  1  serial line, asynchronous, idle high
sam_tick  input  1  one-clk-wide oversample strobe, OVERSAMPLE per bit
data_out  output  DATA_BITS  received word, valid while data_valid=1
data_valid  output  1  holding register occupied
data_ready  input  1  consumer accepts word on clk edge where data_valid&data_ready
parity_err  output  1  parity mismatch for held word (0 when PARITY=0)
frame_err  output  1  a stop bit sampled 0 for held word
overrun  output  1  held word overwrote an unconsumed word
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (reset_n=0, async): FSM=IDLE, counters 0, rx synchroniser flops=1, data_out=0, data_valid/parity_err/frame_err/overrun/busy=0.
- rx passes through a 2-flop synchroniser; all FSM decisions use the synchronised value (rx_s). Latency rx->rx_s = 2 clk.
- s_count: width clog2(OVERSAMPLE), advances only on sam_tick. b_count: width clog2(DATA_BITS+1).
- IDLE: rx_s=0 -> START, s_count=0. busy=0 only here.
- START: on sam_tick, at s_count=OVERSAMPLE/2-1 (bit midpoint) sample rx_s; 1 -> IDLE (glitch rejected, no output change); 0 -> DATA, s_count=0, b_count=0.
- DATA: on sam_tick, at s_count=OVERSAMPLE-1 (next midpoint) sample, shift into shift register LSB-first, s_count=0; after DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
- PARITY: one midpoint sample; odd: XOR(data,parity bit) must be 1; even: must be 0; mismatch latches internal perr.
- STOP: STOP_BITS midpoint samples; any 0 latches internal ferr. On last stop sample: load holding register and flags, next state IDLE if ferr=0, RECOVER if ferr=1. FSM leaves STOP at stop-bit midpoint so a back-to-back start bit is not missed.
- RECOVER: wait until rx_s=1 (break / line stuck low), then IDLE. No further words produced while rx_s=0.
- Holding register load (cycle after last stop sample): data_out, parity_err, frame_err updated, data_valid=1, overrun=1 iff data_valid=1 and not being consumed that same cycle, else 0.
- Consume: data_valid&data_ready at clk edge -> data_valid=0, parity_err/frame_err/overrun=0, data_out holds last value.
- Simultaneous consume and load: new word loaded, data_valid stays 1, overrun=0.
- data_ready with data_valid=0: no effect.
- Reset mid-frame: frame discarded, all outputs to reset values immediately.
- sam_tick ignored in IDLE/RECOVER; in other states, no progress without sam_tick.

Optional Feature:
UART_RX_MAJORITY_EN: defined -> each bit (start, data, parity, stop) decided by 2-of-3 majority of rx_s at the midpoint tick and the ticks immediately before and after it; decision point moves one tick later (sample at midpoint+1), frame timing otherwise identical. Not defined -> single sample of rx_s at midpoint tick.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5 with data_ready=0 -> data_valid=1, data_out=0xA5, parity_err=frame_err=overrun=0; pulse data_ready -> data_valid=0 next edge.
- PARITY=1, send 0x3C with parity bit 1 -> parity_err=0; same data with parity bit 0 -> parity_err=1, data_out=0x3C.
- rx low for 4 sam_ticks then high -> FSM returns IDLE, data_valid stays 0, no frame produced; following valid frame 0x55 received correctly.
- Two back-to-back frames 0x11, 0x22, data_ready=0 -> after second, data_out=0x22, overrun=1; consume -> overrun=0.
- Stop bit forced 0 then rx held low 40 bit periods -> one word with frame_err=1, FSM stays RECOVER, no more words until rx high; then 0x7E received cleanly.
- Assert reset_n=0 during DATA bit 4, release, send 0x81 -> only 0x81 delivered, all flags 0.
